seq_alu: RTL and testbench

//  8-bit multi-cycle ALU. Operands arrive serially on one 8-bit input bus; an FSM sequences
//  add, subtract, shift-add multiply and restoring divide. The result is driven on an 8-bit

---
 rtl/seq_alu_pkg.sv | 34 +++
 rtl/adder_rca.sv | 26 ++
 rtl/seq_alu.sv | 157 +++++++++++++++
 tb/tb_seq_alu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and the one-hot FSM encoding.
package seq_alu_pkg;

    localparam int unsigned STATE_BITS = 17;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    // Each state value carries a single set bit at its state index.
    typedef enum logic [STATE_BITS-1:0] {
        S_IDLE        = 17'h00001,
        S_LOAD_A      = 17'h00002,
        S_LOAD_B      = 17'h00004,
        S_DISPATCH    = 17'h00008,
        S_ADD         = 17'h00010,
        S_SUB         = 17'h00020,
        S_MUL_INIT    = 17'h00040,
        S_MUL_TEST    = 17'h00080,
        S_MUL_ADD     = 17'h00100,
        S_MUL_SHIFT   = 17'h00200,
        S_MUL_CNT     = 17'h00400,
        S_DIV_INIT    = 17'h00800,
        S_DIV_SHIFT   = 17'h01000,
        S_DIV_SUB     = 17'h02000,
        S_DIV_RESTORE = 17'h04000,
        S_DIV_CNT     = 17'h08000,
        S_DONE        = 17'h10000
    } state_e;

endpackage

// File: rtl/adder_rca.sv
// Ripple-carry adder with carry-in; the single arithmetic unit shared by every ALU operation.
module adder_rca #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle 8-bit ALU: serial operand load, one-hot FSM sequencing add/sub,
// shift-add multiply and restoring divide over one shared ripple-carry adder.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned N_STATES = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                BEGIN,
    input  logic [1:0]          op_code,
    input  logic [WIDTH-1:0]    inbus,
    output logic [WIDTH-1:0]    outbus,
    output logic                END,
    output logic [N_STATES-1:0] act_state_debug,
    output logic [N_STATES-1:0] next_state_debug
);

    state_e           state, state_next;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, r_q, q_q;
    logic [WIDTH:0]   acc_q;   // mul: {carry, acc}; div: 9-bit remainder, bit WIDTH is sign after subtract
    logic [3:0]       cnt_q;

    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;

    adder_rca #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        add_a   = a_q;
        add_b   = b_q;
        add_cin = 1'b0;
        case (state)
            S_SUB: begin
                add_b   = ~b_q;
                add_cin = 1'b1;
            end
            S_MUL_ADD: begin
                add_a = acc_q[WIDTH-1:0];
                add_b = a_q;
            end
            S_DIV_SUB: begin
                add_a   = acc_q[WIDTH-1:0];
                add_b   = ~b_q;
                add_cin = 1'b1;
            end
            S_DIV_RESTORE: begin
                add_a = acc_q[WIDTH-1:0];
                add_b = b_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:        if (BEGIN) state_next = S_LOAD_A;
            S_LOAD_A:      state_next = S_LOAD_B;
            S_LOAD_B:      state_next = S_DISPATCH;
            S_DISPATCH: begin
                case (op_q)
                    OP_ADD:  state_next = S_ADD;
                    OP_SUB:  state_next = S_SUB;
                    OP_MUL:  state_next = S_MUL_INIT;
                    default: state_next = S_DIV_INIT;
                endcase
            end
            S_ADD, S_SUB:  state_next = S_DONE;
            S_MUL_INIT:    state_next = S_MUL_TEST;
            S_MUL_TEST:    state_next = q_q[0] ? S_MUL_ADD : S_MUL_SHIFT;
            S_MUL_ADD:     state_next = S_MUL_SHIFT;
            S_MUL_SHIFT:   state_next = S_MUL_CNT;
            S_MUL_CNT:     state_next = (cnt_q == 4'd7) ? S_DONE : S_MUL_TEST;
            S_DIV_INIT:    state_next = (b_q == '0) ? S_DONE : S_DIV_SHIFT;
            S_DIV_SHIFT:   state_next = S_DIV_SUB;
            S_DIV_SUB:     state_next = S_DIV_RESTORE;
            S_DIV_RESTORE: state_next = S_DIV_CNT;
            S_DIV_CNT:     state_next = (cnt_q == 4'd7) ? S_DONE : S_DIV_SHIFT;
            S_DONE:        state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_ADD;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            q_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE:       if (BEGIN) op_q <= op_e'(op_code);
                S_LOAD_A:     a_q <= inbus;
                S_LOAD_B:     b_q <= inbus;
                S_ADD, S_SUB: r_q <= add_sum;
                S_MUL_INIT: begin
                    acc_q <= '0;
                    q_q   <= b_q;
                    cnt_q <= '0;
                end
                S_MUL_ADD:    acc_q <= {add_cout, add_sum};
                S_MUL_SHIFT: begin
                    acc_q <= {1'b0, acc_q[WIDTH:1]};
                    q_q   <= {acc_q[0], q_q[WIDTH-1:1]};
                end
                S_MUL_CNT, S_DIV_CNT: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd7) r_q <= q_q;
                end
                S_DIV_INIT: begin
                    acc_q <= '0;
                    q_q   <= a_q;
                    cnt_q <= '0;
                    if (b_q == '0) r_q <= '1;
                end
                S_DIV_SHIFT: begin
                    acc_q <= {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
                    q_q   <= {q_q[WIDTH-2:0], 1'b0};
                end
                // Remainder stays within one sign bit of range, so bit WIDTH minus borrow gives the sign.
                S_DIV_SUB:    acc_q <= {acc_q[WIDTH] ^ ~add_cout, add_sum};
                S_DIV_RESTORE: begin
                    if (acc_q[WIDTH]) begin
                        acc_q  <= {1'b0, add_sum};
                        q_q[0] <= 1'b0;
                    end else begin
                        q_q[0] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign outbus           = r_q;
    assign END              = (state == S_DONE);
    assign act_state_debug  = state;
    assign next_state_debug = state_next;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, hand-built corner sequences,
// randomized operations against an arithmetic reference, and a per-cycle FSM monitor.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        BEGIN;
    logic [1:0]  op_code;
    logic [7:0]  inbus;
    logic [7:0]  outbus;
    logic        END;
    logic [16:0] act_state_debug;
    logic [16:0] next_state_debug;

    int checks = 0, errors = 0;
    int mon_checks = 0, mon_errors = 0;

    seq_alu #(.WIDTH(8), .N_STATES(17)) dut (
        .clk              (clk),
        .reset            (reset),
        .BEGIN            (BEGIN),
        .op_code          (op_code),
        .inbus            (inbus),
        .outbus           (outbus),
        .END              (END),
        .act_state_debug  (act_state_debug),
        .next_state_debug (next_state_debug)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ua, ub, x;
        ua = 32'(a);
        ub = 32'(b);
        case (op)
            2'b00:   x = ua + ub;
            2'b01:   x = 32'd256 + ua - ub;
            2'b10:   x = ua * ub;
            default: x = (ub == 0) ? 32'd255 : ua / ub;
        endcase
        return 8'(x);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output int lat);
        @(posedge clk); #1;
        BEGIN = 1'b1; op_code = op; inbus = 8'h00;
        @(posedge clk); #1;
        BEGIN = 1'b0; inbus = a; lat = 1;
        @(posedge clk); #1;
        inbus = b; lat = 2;
        while (lat < 60) begin
            @(negedge clk);
            if (END) break;
            @(posedge clk); #1;
            lat++;
        end
        res = outbus;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!END && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Per-cycle FSM invariants; the comparison chain restarts across any reset.
    logic [16:0] prev_next;
    bit          have_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            have_prev = 1'b0;
        end else begin
            mon_checks++;
            if (!$onehot(act_state_debug)) begin
                mon_errors++;
                $display("FAIL onehot got=%05h want=one-hot", act_state_debug);
            end
            mon_checks++;
            if (END !== act_state_debug[16]) begin
                mon_errors++;
                $display("FAIL end_vs_done got=%0b want=%0b", END, act_state_debug[16]);
            end
            if (have_prev) begin
                mon_checks++;
                if (act_state_debug !== prev_next) begin
                    mon_errors++;
                    $display("FAIL next_state got=%05h want=%05h", act_state_debug, prev_next);
                end
            end
            prev_next = next_state_debug;
            have_prev = 1'b1;
        end
    end

    initial begin
        logic [7:0] res;
        int         lat;
        int         n;
        logic [1:0] rop;
        logic [7:0] ra, rb;

        vecs[0]  = '{2'b00, 8'd3,   8'd2,   8'd5};
        vecs[1]  = '{2'b01, 8'd2,   8'd3,   8'hFF};
        vecs[2]  = '{2'b01, 8'd9,   8'd4,   8'd5};
        vecs[3]  = '{2'b10, 8'd7,   8'd3,   8'd21};
        vecs[4]  = '{2'b10, 8'd16,  8'd16,  8'd0};
        vecs[5]  = '{2'b11, 8'd100, 8'd7,   8'd14};
        vecs[6]  = '{2'b11, 8'd5,   8'd0,   8'hFF};
        vecs[7]  = '{2'b00, 8'd200, 8'd100, 8'd44};
        vecs[8]  = '{2'b10, 8'd255, 8'd255, 8'd1};
        vecs[9]  = '{2'b11, 8'd255, 8'd1,   8'd255};
        vecs[10] = '{2'b11, 8'd7,   8'd9,   8'd0};
        vecs[11] = '{2'b11, 8'd255, 8'd16,  8'd15};
        vecs[12] = '{2'b10, 8'd0,   8'd123, 8'd0};
        vecs[13] = '{2'b11, 8'd0,   8'd5,   8'd0};

        reset = 1'b1; BEGIN = 1'b0; op_code = 2'b00; inbus = 8'h00;
        #7;
        check("reset_state", 32'(act_state_debug), 32'h00001);
        check("reset_outbus", 32'(outbus), 32'h0);
        check("reset_end", 32'(END), 32'h0);
        #3 reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp));
            if (vecs[i].op[1] == 1'b0) check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            else                       check($sformatf("vec%0d_in_budget", i), 32'(lat <= 44), 32'd1);
        end

        // BEGIN held through DONE: back-to-back add then sub.
        @(posedge clk); #1;
        BEGIN = 1'b1; op_code = 2'b00;
        @(posedge clk); #1; inbus = 8'd10;
        @(posedge clk); #1; inbus = 8'd20;
        wait_end(n);
        check("hold_first_end_seen", 32'(END), 32'd1);
        check("hold_first_result", 32'(outbus), 32'd30);
        op_code = 2'b01; inbus = 8'h00;
        @(posedge clk); #1;
        check("hold_idle_after_done", 32'(act_state_debug), 32'h00001);
        check("hold_end_one_cycle", 32'(END), 32'd0);
        @(posedge clk); #1;
        check("hold_restart_load_a", 32'(act_state_debug), 32'h00002);
        BEGIN = 1'b0; inbus = 8'd50;
        @(posedge clk); #1; inbus = 8'd8;
        wait_end(n);
        check("hold_second_end_seen", 32'(END), 32'd1);
        check("hold_second_result", 32'(outbus), 32'd42);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        BEGIN = 1'b1; op_code = 2'b10;
        @(posedge clk); #1; BEGIN = 1'b0; inbus = 8'd255;
        @(posedge clk); #1; inbus = 8'd255;
        repeat (10) @(posedge clk);
        #1;
        check("abort_was_in_mul", 32'(|act_state_debug[10:6]), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_state", 32'(act_state_debug), 32'h00001);
        check("abort_outbus", 32'(outbus), 32'h0);
        check("abort_end", 32'(END), 32'h0);
        check("abort_next_state", 32'(next_state_debug), 32'h00001);
        @(posedge clk); #2 reset = 1'b0;
        run_op(2'b11, 8'd200, 8'd3, res, lat);
        check("post_abort_div", 32'(res), 32'd66);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(rop, ra, rb, res, lat);
            check($sformatf("rand%0d_op%0d_%0d_%0d", i, rop, ra, rb), 32'(res), 32'(ref_alu(rop, ra, rb)));
            if (rop[1] == 1'b0) check($sformatf("rand%0d_latency", i), 32'(lat), 32'd5);
            else                check($sformatf("rand%0d_in_budget", i), 32'(lat <= 44), 32'd1);
        end

        @(posedge clk);
        @(negedge clk);
        checks += mon_checks;
        errors += mon_errors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
